// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory loader.
//   ld_state_e  : loader state (LOAD, RUN, ERR)
//   IMEM_AW_DEF : default instruction word-address width
//   IW_DEF      : default instruction width
//   LD_PAD      : low byte used to pad an odd trailing byte
package mips_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } ld_state_e;

  localparam int unsigned IMEM_AW_DEF = 8;
  localparam int unsigned IW_DEF      = 16;
  localparam logic [7:0]  LD_PAD      = 8'h00;

endpackage

// File: rtl/imem_ram.sv
// Instruction RAM: 2^AW words of DW bits, one synchronous write port and one
// asynchronous (zero-cycle) read port. Contents are not reset.
//   i_clk   : clock
//   i_we    : write enable
//   i_waddr : write word address
//   i_wdata : write data
//   i_raddr : read word address
//   o_rdata : read data (combinational)
module imem_ram #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  localparam int unsigned Depth = 1 << AW;

  logic [DW-1:0] r_mem [Depth];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/imem_loader.sv
// Byte-stream loader for the core's instruction memory. Bytes are paired
// big-endian into 16-bit words and written sequentially from address 0; the
// core is held in reset until the byte flagged ld_last is accepted.
// Optional feature macro: IMEM_CHECKSUM_EN -- the ld_last byte is an XOR
// checksum of all preceding bytes instead of data.
//   i_clk      : clock, rising edge
//   i_reset    : synchronous active-low reset
//   i_ld_valid : loader byte valid
//   i_ld_byte  : loader data byte
//   i_ld_last  : final byte of the image (qualified by i_ld_valid)
//   o_ld_ready : byte accepted when i_ld_valid & o_ld_ready
//   i_pc       : word address from the core
//   o_instr    : instruction to the core
//   o_cpu_rst  : active-high core hold
//   o_loaded   : image complete, core running
//   o_ld_err   : sticky load error (overflow or checksum mismatch)
module imem_loader
  import mips_pkg::*;
#(
  parameter int unsigned IMEM_AW = IMEM_AW_DEF,
  parameter int unsigned IW      = IW_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_ld_valid,
  input  logic [7:0]         i_ld_byte,
  input  logic               i_ld_last,
  output logic               o_ld_ready,
  input  logic [IMEM_AW-1:0] i_pc,
  output logic [IW-1:0]      o_instr,
  output logic               o_cpu_rst,
  output logic               o_loaded,
  output logic               o_ld_err
);

  ld_state_e          r_state;
  logic [IMEM_AW:0]   r_word_cnt;  // one extra bit so a full RAM is representable
  logic               r_have_hi;
  logic [7:0]         r_hi;
  logic               r_ld_ready;
  logic               r_cpu_rst;
  logic               r_loaded;
  logic               r_ld_err;

  logic               w_accept;
  logic               w_full;
  logic               w_we;
  logic [IW-1:0]      w_wdata;
  logic               w_hold_hi;
  logic               w_overflow;
  logic               w_done_ok;
  logic               w_done_bad;
  logic [IW-1:0]      w_rdata;

  assign w_accept = i_ld_valid && r_ld_ready && (r_state == LOAD);
  assign w_full   = r_word_cnt[IMEM_AW];

`ifdef IMEM_CHECKSUM_EN
  logic [7:0] r_csum;
  logic       w_csum_ok;

  assign w_csum_ok  = (i_ld_byte == r_csum);
  // The checksum byte is never stored, so it cannot overflow the RAM.
  assign w_overflow = w_accept && w_full && !i_ld_last;
  assign w_done_ok  = w_accept && i_ld_last && w_csum_ok;
  assign w_done_bad = w_accept && i_ld_last && !w_csum_ok;
  assign w_hold_hi  = w_accept && !i_ld_last && !w_full && !r_have_hi;

  always_comb begin
    w_we    = 1'b0;
    w_wdata = IW'({r_hi, i_ld_byte});
    if (w_accept && r_have_hi) begin
      if (i_ld_last) begin
        w_we    = w_csum_ok;
        w_wdata = IW'({r_hi, LD_PAD});
      end else begin
        w_we    = !w_full;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_csum <= 8'h00;
    end else if (w_accept) begin
      r_csum <= r_csum ^ i_ld_byte;
    end
  end
`else
  assign w_overflow = w_accept && w_full;
  assign w_done_ok  = w_accept && !w_full && i_ld_last;
  assign w_done_bad = 1'b0;
  assign w_hold_hi  = w_accept && !w_full && !r_have_hi && !i_ld_last;

  always_comb begin
    w_we    = w_accept && !w_full && (r_have_hi || i_ld_last);
    // A lone trailing byte becomes the high byte of a padded word.
    w_wdata = r_have_hi ? IW'({r_hi, i_ld_byte}) : IW'({i_ld_byte, LD_PAD});
  end
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state    <= LOAD;
      r_word_cnt <= '0;
      r_have_hi  <= 1'b0;
      r_hi       <= 8'h00;
      r_ld_ready <= 1'b1;
      r_cpu_rst  <= 1'b1;
      r_loaded   <= 1'b0;
      r_ld_err   <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_we) begin
            r_word_cnt <= r_word_cnt + 1'b1;
          end
          if (w_hold_hi) begin
            r_hi      <= i_ld_byte;
            r_have_hi <= 1'b1;
          end else if (w_we) begin
            r_have_hi <= 1'b0;
          end
          if (w_overflow || w_done_bad) begin
            r_state    <= ERR;
            r_ld_ready <= 1'b0;
            r_ld_err   <= 1'b1;
          end else if (w_done_ok) begin
            r_state    <= RUN;
            r_ld_ready <= 1'b0;
            r_cpu_rst  <= 1'b0;
            r_loaded   <= 1'b1;
            r_have_hi  <= 1'b0;
          end
        end
        RUN, ERR: ;  // only reset leaves these states
        default: begin
          r_state    <= ERR;
          r_ld_ready <= 1'b0;
          r_cpu_rst  <= 1'b1;
          r_loaded   <= 1'b0;
          r_ld_err   <= 1'b1;
        end
      endcase
    end
  end

  imem_ram #(
    .AW (IMEM_AW),
    .DW (IW)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (r_word_cnt[IMEM_AW-1:0]),
    .i_wdata (w_wdata),
    .i_raddr (i_pc),
    .o_rdata (w_rdata)
  );

  assign o_instr    = ((r_state == RUN) && ({1'b0, i_pc} < r_word_cnt)) ? w_rdata : '0;
  assign o_ld_ready = r_ld_ready;
  assign o_cpu_rst  = r_cpu_rst;
  assign o_loaded   = r_loaded;
  assign o_ld_err   = r_ld_err;

endmodule
